cpu_core: RTL and testbench
===========================

# cpu_core

Multi-cycle 16-bit-register processor that runs a program from a 1K×32 instruction RAM against a 64K×8 data RAM, then raises `finish`. It sits beside the I/O manager: the manager loads data RAM over UART, asserts `enable`, waits for `finish`, drops `enable`, and streams data RAM back out. Both RAMs are external synchronous-read blocks on the core clock.

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-low. One clock; reset is synchronous and active-low.
- `enable` in 1: 1 = run; 0 = freeze all state.
- `data_ram_we` out 1: data RAM write strobe.
- `addr_data_ram` out 16: data RAM address.
- `din_data_ram` out 8: data RAM write data.
- `dout_data_ram` in 8: data RAM read data, valid one cycle after address.
- `inst_ram_we` out 1: always 0.
- `addr_inst_ram` out 10: instruction address (= PC).
- `din_inst_ram` out 32: always 0.
- `dout_inst_ram` in 32: instruction word, valid one cycle after address.
- `finish` out 1: program reached HALT.

## Operation
- State: PC[9:0], IR[31:0], R0–R15 (16-bit; R0 reads 0, writes ignored), FSM.
- Format: op=IR[31:28], rd=[27:24], ra=[23:20], rb=[19:16], imm=[15:0].
- Opcodes: 0 NOP; 1 LDI rd=imm; 2 LOAD rd={8'h00,mem[ra]}; 3 STORE mem[ra]=rb[7:0]; 4 ADD rd=ra+rb; 5 SUB rd=ra−rb; 6 ADDI rd=ra+imm; 7 SHR rd=ra>>imm[3:0] (logical); 8 SHL rd=ra<<imm[3:0]; 9 AND rd=ra&rb; A JMP PC=imm[9:0]; B JZ if ra==0 PC=imm[9:0]; C JNZ if ra!=0 PC=imm[9:0]; F HALT; D,E act as NOP.
- Arithmetic modulo 2^16, no flags. PC increments modulo 1024 (1023→0).
- FSM: FETCH → DECODE (IR←dout_inst_ram) → EXEC → FETCH; LOAD takes EXEC → MEMRD → FETCH; HALT goes EXEC → DONE.
- EXEC: ALU writeback, PC update (PC+1, or target for taken jump), STORE strobe.
- MEMRD: rd←{8'h00,dout_data_ram}, PC+1.
- DONE: absorbing; `finish`=1; only reset leaves it.
- `addr_inst_ram`=PC always. `addr_data_ram`=R[ra], `din_data_ram`=R[rb][7:0] while IR holds LOAD/STORE; otherwise 0.
- `data_ram_we`=1 only in EXEC with op STORE and `enable`=1.
- `enable`=0: FSM, PC, IR, registers hold; `data_ram_we`=0; `finish` keeps value.

## Timing
- Reset (reset=0 at edge): PC=0, IR=0, all regs 0, FSM=FETCH, `finish`=0, `data_ram_we`=0, `addr_data_ram`=0, `din_data_ram`=0, `addr_inst_ram`=0. Overrides `enable` and any state including DONE.
- Cycles per instruction with enable held: 3 (ALU/STORE/jump/NOP), 4 (LOAD); HALT: `finish` high 3 cycles after its FETCH begins.
- STORE write occurs on the edge ending EXEC.
- `enable` dropping mid-instruction pauses exactly; resumption continues same state, no replay or skip.
- Jump to self with no HALT loops forever, `finish` stays 0.

## Test plan
- Reset with enable=1: all outputs 0; after release, `addr_inst_ram`=0, then 1 after three cycles (NOP at 0).
- LDI R1,0x0010; LDI R2,0x00AB; STORE [R1],R2; HALT → single-cycle `data_ram_we` with addr 0x0010, din 0xAB; `finish` high, remains high.
- mem[5]=0x7F; LDI R1,5; LOAD R3,[R1]; ADDI R3,R3,1; STORE [R1],R3; HALT → mem[5]=0x80.
- Loop: LDI R1,4; LDI R2,0; ADDI R2,R2,3; ADDI R1,R1,0xFFFF; JNZ R1,2; STORE [R0],R2; HALT → mem[0]=0x0C.
- SUB wrap: R1=0, R2=1, SUB R3,R1,R2; SHR R4,R3,8; STORE → low byte 0xFF; R0 written stays 0.
- Toggle enable low for 5 cycles mid-LOAD → outputs frozen, no write; final memory identical to uninterrupted run; reset during DONE clears `finish` next edge.

Source files
------------

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 16-bit register machine.
// Fetches 32-bit instructions from an external instruction RAM and works on
// an external byte-wide data RAM. It raises finish when it executes HALT.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | PC is on addr_inst_ram; the instruction RAM is reading the word
// DECODE| IR <= dout_inst_ram
// EXEC  | ALU writeback, PC update, STORE strobe; LOAD address presented
// MEMRD | rd <= {8'h00, dout_data_ram}, PC+1 (LOAD only)
// DONE  | HALT reached; finish=1 until reset
module cpu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        data_ram_we,
    output logic [15:0] addr_data_ram,
    output logic [7:0]  din_data_ram,
    input  logic [7:0]  dout_data_ram,
    output logic        inst_ram_we,
    output logic [9:0]  addr_inst_ram,
    output logic [31:0] din_inst_ram,
    input  logic [31:0] dout_inst_ram,
    output logic        finish
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEMRD  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_ADDI  = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_pc;
    logic [31:0] r_ir;
    logic [15:0] r_regs [16];

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [15:0] w_imm;
    logic [15:0] w_ra_val;
    logic [15:0] w_rb_val;
    logic [15:0] w_alu_result;
    logic        w_alu_we;
    logic        w_jump_taken;
    logic        w_is_mem_op;

    assign w_op  = r_ir[31:28];
    assign w_rd  = r_ir[27:24];
    assign w_ra  = r_ir[23:20];
    assign w_rb  = r_ir[19:16];
    assign w_imm = r_ir[15:0];

    // R0 is hard-wired to zero on read
    assign w_ra_val = (w_ra == 4'd0) ? 16'h0000 : r_regs[w_ra];
    assign w_rb_val = (w_rb == 4'd0) ? 16'h0000 : r_regs[w_rb];

    // ALU result and writeback qualifier for register-writing opcodes
    always_comb begin
        w_alu_result = 16'h0000;
        w_alu_we     = 1'b0;
        case (w_op)
            OP_LDI:  begin w_alu_result = w_imm;                   w_alu_we = 1'b1; end
            OP_ADD:  begin w_alu_result = w_ra_val + w_rb_val;     w_alu_we = 1'b1; end
            OP_SUB:  begin w_alu_result = w_ra_val - w_rb_val;     w_alu_we = 1'b1; end
            OP_ADDI: begin w_alu_result = w_ra_val + w_imm;        w_alu_we = 1'b1; end
            OP_SHR:  begin w_alu_result = w_ra_val >> w_imm[3:0];  w_alu_we = 1'b1; end
            OP_SHL:  begin w_alu_result = w_ra_val << w_imm[3:0];  w_alu_we = 1'b1; end
            OP_AND:  begin w_alu_result = w_ra_val & w_rb_val;     w_alu_we = 1'b1; end
            default: begin w_alu_result = 16'h0000;                w_alu_we = 1'b0; end
        endcase
    end

    // Branch decision for JMP/JZ/JNZ
    always_comb begin
        w_jump_taken = 1'b0;
        case (w_op)
            OP_JMP:  w_jump_taken = 1'b1;
            OP_JZ:   w_jump_taken = (w_ra_val == 16'h0000);
            OP_JNZ:  w_jump_taken = (w_ra_val != 16'h0000);
            default: w_jump_taken = 1'b0;
        endcase
    end

    // State register; enable=0 freezes the sequencer in place
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else if (enable) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = ST_EXEC;
            ST_EXEC: begin
                if (w_op == OP_LOAD)
                    w_state_next = ST_MEMRD;
                else if (w_op == OP_HALT)
                    w_state_next = ST_DONE;
                else
                    w_state_next = ST_FETCH;
            end
            ST_MEMRD:  w_state_next = ST_FETCH;
            ST_DONE:   w_state_next = ST_DONE;
            default:   w_state_next = ST_FETCH;
        endcase
    end

    // Output decode; data RAM address/data only reflect registers for LOAD/STORE
    always_comb begin
        w_is_mem_op   = (w_op == OP_LOAD) || (w_op == OP_STORE);
        addr_data_ram = w_is_mem_op ? w_ra_val : 16'h0000;
        din_data_ram  = w_is_mem_op ? w_rb_val[7:0] : 8'h00;
        data_ram_we   = (r_state == ST_EXEC) && (w_op == OP_STORE) && enable;
        finish        = (r_state == ST_DONE);
    end

    assign inst_ram_we   = 1'b0;
    assign din_inst_ram  = 32'h0000_0000;
    assign addr_inst_ram = r_pc;

    // Datapath: PC, IR and register file updates per state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= 10'd0;
            r_ir <= 32'h0000_0000;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (enable) begin
            case (r_state)
                ST_DECODE: r_ir <= dout_inst_ram;
                ST_EXEC: begin
                    if (w_alu_we && (w_rd != 4'd0))
                        r_regs[w_rd] <= w_alu_result;
                    if (w_op == OP_HALT || w_op == OP_LOAD)
                        r_pc <= r_pc;
                    else if (w_jump_taken)
                        r_pc <= w_imm[9:0];
                    else
                        r_pc <= r_pc + 10'd1;
                end
                ST_MEMRD: begin
                    if (w_rd != 4'd0)
                        r_regs[w_rd] <= {8'h00, dout_data_ram};
                    r_pc <= r_pc + 10'd1;
                end
                default: r_pc <= r_pc;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: synchronous-read RAM models, a table of
// single-ALU-op programs, and hand-written multi-cycle sequences.
module tb_cpu_core;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        data_ram_we;
    logic [15:0] addr_data_ram;
    logic [7:0]  din_data_ram;
    logic [7:0]  dout_data_ram;
    logic        inst_ram_we;
    logic [9:0]  addr_inst_ram;
    logic [31:0] din_inst_ram;
    logic [31:0] dout_inst_ram;
    logic        finish;

    logic [31:0] imem [1024];
    logic [7:0]  dmem [65536];

    int checks = 0;
    int errors = 0;

    cpu_core dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_ram_we   (data_ram_we),
        .addr_data_ram (addr_data_ram),
        .din_data_ram  (din_data_ram),
        .dout_data_ram (dout_data_ram),
        .inst_ram_we   (inst_ram_we),
        .addr_inst_ram (addr_inst_ram),
        .din_inst_ram  (din_inst_ram),
        .dout_inst_ram (dout_inst_ram),
        .finish        (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAMs
    always @(posedge clk) begin
        dout_inst_ram <= imem[addr_inst_ram];
        dout_data_ram <= dmem[addr_data_ram];
        if (data_ram_we) dmem[addr_data_ram] = din_data_ram;
    end

    typedef struct {
        logic [31:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [15:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        for (int i = 0; i < 65536; i++) dmem[i] = 8'h00;
    endtask

    // One reset edge with enable high, then release; returns at a negedge with state=FETCH
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        reset  = 1'b1;
    endtask

    task automatic run_to_finish(input int max, output int n);
        n = 0;
        while (!finish && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    vec_t vecs[13];
    int   n;
    int   we_count;
    logic [15:0] we_addr;
    logic [7:0]  we_din;
    logic [47:0] snap;
    int   frozen_bad;

    initial begin
        vecs[0]  = '{enc(4'h4, 4'd3, 4'd1, 4'd2, 16'h0000), 16'h1234, 16'h0FFF, 16'h2233, "add"};
        vecs[1]  = '{enc(4'h4, 4'd3, 4'd1, 4'd2, 16'h0000), 16'hFFFF, 16'h0002, 16'h0001, "add_wrap"};
        vecs[2]  = '{enc(4'h5, 4'd3, 4'd1, 4'd2, 16'h0000), 16'h0000, 16'h0001, 16'hFFFF, "sub_wrap"};
        vecs[3]  = '{enc(4'h5, 4'd3, 4'd1, 4'd2, 16'h0000), 16'h5000, 16'h1234, 16'h3DCC, "sub"};
        vecs[4]  = '{enc(4'h6, 4'd3, 4'd1, 4'd0, 16'h0002), 16'hFFFF, 16'h0000, 16'h0001, "addi_wrap"};
        vecs[5]  = '{enc(4'h7, 4'd3, 4'd1, 4'd0, 16'h0004), 16'h8001, 16'h0000, 16'h0800, "shr4"};
        vecs[6]  = '{enc(4'h7, 4'd3, 4'd1, 4'd0, 16'h0013), 16'h8001, 16'h0000, 16'h1000, "shr_imm_lowbits"};
        vecs[7]  = '{enc(4'h8, 4'd3, 4'd1, 4'd0, 16'h0001), 16'h8001, 16'h0000, 16'h0002, "shl1"};
        vecs[8]  = '{enc(4'h8, 4'd3, 4'd1, 4'd0, 16'h000F), 16'h8001, 16'h0000, 16'h8000, "shl15"};
        vecs[9]  = '{enc(4'h9, 4'd3, 4'd1, 4'd2, 16'h0000), 16'hF0F0, 16'h3C3C, 16'h3030, "and"};
        vecs[10] = '{enc(4'h1, 4'd3, 4'd0, 4'd0, 16'hBEEF), 16'h1111, 16'h2222, 16'hBEEF, "ldi"};
        vecs[11] = '{enc(4'hE, 4'd3, 4'd1, 4'd2, 16'hFFFF), 16'h1111, 16'h2222, 16'h0000, "op_e_nop"};
        vecs[12] = '{enc(4'h4, 4'd0, 4'd1, 4'd2, 16'h0000), 16'h1111, 16'h2222, 16'h0000, "r0_write"};

        reset  = 1'b0;
        enable = 1'b1;
        clear_mem();

        // Reset state and first fetch progression
        repeat (2) @(negedge clk);
        check("rst_we", {31'b0, data_ram_we}, 32'h0);
        check("rst_addr_data", {16'h0, addr_data_ram}, 32'h0);
        check("rst_din_data", {24'h0, din_data_ram}, 32'h0);
        check("rst_addr_inst", {22'h0, addr_inst_ram}, 32'h0);
        check("rst_finish", {31'b0, finish}, 32'h0);
        check("rst_inst_we_din", {31'b0, inst_ram_we} | din_inst_ram, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("pc_mid_nop", {22'h0, addr_inst_ram}, 32'h0);
        @(negedge clk);
        check("pc_after_nop", {22'h0, addr_inst_ram}, 32'h1);

        // Table of single ALU operations; result spread across mem[0] (low) and mem[1] (high)
        foreach (vecs[k]) begin
            clear_mem();
            imem[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, vecs[k].a);
            imem[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, vecs[k].b);
            imem[2] = vecs[k].instr;
            imem[3] = enc(4'h3, 4'd0, 4'd0, 4'd3, 16'h0);
            imem[4] = enc(4'h7, 4'd4, 4'd3, 4'd0, 16'h0008);
            imem[5] = enc(4'h1, 4'd5, 4'd0, 4'd0, 16'h0001);
            imem[6] = enc(4'h3, 4'd0, 4'd5, 4'd4, 16'h0);
            imem[7] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
            dmem[0] = 8'h5A;
            dmem[1] = 8'hA5;
            do_reset();
            run_to_finish(200, n);
            check({vecs[k].name, "_finish"}, {31'b0, finish}, 32'h1);
            check(vecs[k].name, {16'h0, dmem[1], dmem[0]}, {16'h0, vecs[k].exp});
        end

        // STORE strobe, HALT latency and sticky finish
        clear_mem();
        imem[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0010);
        imem[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h00AB);
        imem[2] = enc(4'h3, 4'd0, 4'd1, 4'd2, 16'h0);
        imem[3] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
        do_reset();
        we_count = 0;
        we_addr  = 16'h0;
        we_din   = 8'h0;
        n = 0;
        while (!finish && n < 100) begin
            @(negedge clk);
            n++;
            if (data_ram_we) begin
                we_count++;
                we_addr = addr_data_ram;
                we_din  = din_data_ram;
            end
        end
        check("store_halt_cycles", n, 32'd12);
        repeat (10) begin
            @(negedge clk);
            if (data_ram_we) we_count++;
        end
        check("store_we_pulses", we_count, 32'd1);
        check("store_addr_din", {8'h0, we_addr, we_din}, {8'h0, 16'h0010, 8'hAB});
        check("store_mem", {24'h0, dmem[16]}, 32'hAB);
        check("finish_sticky", {31'b0, finish}, 32'h1);

        // Reset during DONE clears finish on the next edge
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_done_finish", {31'b0, finish}, 32'h0);
        check("reset_in_done_pc", {22'h0, addr_inst_ram}, 32'h0);
        reset = 1'b1;

        // LOAD / increment / STORE, uninterrupted
        clear_mem();
        dmem[5] = 8'h7F;
        imem[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0005);
        imem[1] = enc(4'h2, 4'd3, 4'd1, 4'd0, 16'h0);
        imem[2] = enc(4'h6, 4'd3, 4'd3, 4'd0, 16'h0001);
        imem[3] = enc(4'h3, 4'd0, 4'd1, 4'd3, 16'h0);
        imem[4] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
        do_reset();
        run_to_finish(200, n);
        check("load_cycles", n, 32'd16);
        check("load_inc_mem", {24'h0, dmem[5]}, 32'h80);

        // Same program with enable pauses in MEMRD and in STORE's EXEC
        dmem[5] = 8'h7F;
        do_reset();
        repeat (6) @(negedge clk);
        snap = {addr_inst_ram, addr_data_ram, din_data_ram, 5'b0, finish, data_ram_we, 6'b0};
        enable = 1'b0;
        frozen_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({addr_inst_ram, addr_data_ram, din_data_ram, 5'b0, finish, data_ram_we, 6'b0} !== snap)
                frozen_bad++;
        end
        check("memrd_pause_frozen", frozen_bad, 32'd0);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("store_exec_we", {8'h0, data_ram_we, addr_data_ram, din_data_ram},
              {8'h0, 1'b1, 16'h0005, 8'h80});
        enable = 1'b0;
        frozen_bad = 0;
        repeat (3) begin
            #1;
            if (data_ram_we !== 1'b0) frozen_bad++;
            @(negedge clk);
        end
        check("store_pause_no_we", frozen_bad, 32'd0);
        check("store_pause_mem", {24'h0, dmem[5]}, 32'h7F);
        enable = 1'b1;
        run_to_finish(200, n);
        check("pause_remaining_cycles", n, 32'd4);
        check("pause_final_mem", {24'h0, dmem[5]}, 32'h80);

        // Countdown loop with JNZ
        clear_mem();
        dmem[0] = 8'hEE;
        imem[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0004);
        imem[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h0000);
        imem[2] = enc(4'h6, 4'd2, 4'd2, 4'd0, 16'h0003);
        imem[3] = enc(4'h6, 4'd1, 4'd1, 4'd0, 16'hFFFF);
        imem[4] = enc(4'hC, 4'd0, 4'd1, 4'd0, 16'h0002);
        imem[5] = enc(4'h3, 4'd0, 4'd0, 4'd2, 16'h0);
        imem[6] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
        do_reset();
        run_to_finish(500, n);
        check("loop_finish", {31'b0, finish}, 32'h1);
        check("loop_mem0", {24'h0, dmem[0]}, 32'h0C);

        // SUB wrap then SHR; R0 write ignored
        clear_mem();
        dmem[1] = 8'hEE;
        imem[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0000);
        imem[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h0001);
        imem[2] = enc(4'h5, 4'd3, 4'd1, 4'd2, 16'h0);
        imem[3] = enc(4'h7, 4'd4, 4'd3, 4'd0, 16'h0008);
        imem[4] = enc(4'h3, 4'd0, 4'd0, 4'd4, 16'h0);
        imem[5] = enc(4'h1, 4'd0, 4'd0, 4'd0, 16'h0055);
        imem[6] = enc(4'h3, 4'd0, 4'd2, 4'd0, 16'h0);
        imem[7] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
        do_reset();
        run_to_finish(200, n);
        check("subwrap_mem0", {24'h0, dmem[0]}, 32'hFF);
        check("r0_reads_zero", {24'h0, dmem[1]}, 32'h00);
        check("r0_no_store_55", {24'h0, dmem[16'h55]}, 32'h00);

        // PC wraps 1023 -> 0
        clear_mem();
        imem[0]    = enc(4'h6, 4'd1, 4'd1, 4'd0, 16'h0001);
        imem[1]    = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h0002);
        imem[2]    = enc(4'h5, 4'd3, 4'd1, 4'd2, 16'h0);
        imem[3]    = enc(4'hB, 4'd0, 4'd3, 4'd0, 16'h0005);
        imem[4]    = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'h03FF);
        imem[5]    = enc(4'h3, 4'd0, 4'd0, 4'd1, 16'h0);
        imem[6]    = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
        do_reset();
        run_to_finish(300, n);
        check("pc_wrap_finish", {31'b0, finish}, 32'h1);
        check("pc_wrap_mem0", {24'h0, dmem[0]}, 32'h02);

        // Jump to self never finishes
        clear_mem();
        imem[0] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'h0000);
        do_reset();
        run_to_finish(300, n);
        check("self_loop_no_finish", {31'b0, finish}, 32'h0);
        check("self_loop_pc", {22'h0, addr_inst_ram}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
